// File: rtl/meml_pkg.sv
// Shared size defaults for the banked 64x16 RAM.
package meml_pkg;
    localparam int MEML_DATA_W  = 16;
    localparam int MEML_ADDR_W  = 6;
    localparam int MEML_BANK_AW = 5;
endpackage

// File: rtl/ram_32x16.sv
// One RAM bank: flop storage cleared by async reset, registered read port.
module ram_32x16 #(
    parameter int DATA_W = 16,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] q
);
    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read samples the pre-write word, so a same-address collision is read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            q <= '0;
        end else begin
            if (we) mem[waddr] <= d_in;
            if (re) q <= mem[raddr];
        end
    end
endmodule

// File: rtl/meml_ram.sv
// Banked RAM top: address-MSB bank decode, per-bank enables, aligned output mux.
module meml_ram
    import meml_pkg::*;
#(
    parameter int DATA_W  = MEML_DATA_W,
    parameter int ADDR_W  = MEML_ADDR_W,
    parameter int BANK_AW = MEML_BANK_AW
) (
    output logic [DATA_W-1:0] d_out,
    input  logic [DATA_W-1:0] d_in,
    input  logic              rd,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              wr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              clk,
    input  logic              rst
);
    localparam int SEL_W     = ADDR_W - BANK_AW;
    localparam int NUM_BANKS = 1 << SEL_W;

    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_q;
    logic [SEL_W-1:0] wsel, rsel, rsel_q;

    assign wsel = waddr[ADDR_W-1:BANK_AW];
    assign rsel = raddr[ADDR_W-1:BANK_AW];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_32x16 #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (wr && (wsel == SEL_W'(b))),
            .waddr (waddr[BANK_AW-1:0]),
            .d_in  (d_in),
            .re    (rd && (rsel == SEL_W'(b))),
            .raddr (raddr[BANK_AW-1:0]),
            .q     (bank_q[b])
        );
    end

    // Bank choice is captured on the same edge as the bank data so the mux never skews.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rsel_q <= '0;
        else if (rd) rsel_q <= rsel;
    end

    assign d_out = bank_q[rsel_q];
endmodule

// File: tb/tb_meml_ram.sv
// Self-checking bench for meml_ram: directed table, reset sequences, random vs array model.
module tb_meml_ram;
    logic [15:0] d_out, d_in;
    logic        rd, wr, clk, rst;
    logic [5:0]  raddr, waddr;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [64];
    logic [15:0] model_q;

    meml_ram dut (
        .d_out (d_out),
        .d_in  (d_in),
        .rd    (rd),
        .raddr (raddr),
        .wr    (wr),
        .waddr (waddr),
        .clk   (clk),
        .rst   (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        wr;
        bit [5:0]  waddr;
        bit [15:0] d;
        bit        rd;
        bit [5:0]  raddr;
        bit [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_mem[i] = 16'h0000;
        model_q = 16'h0000;
    endtask

    // Drive one cycle, advance the model on the edge, return 1 time unit after the edge.
    task automatic cycle(input bit w, input bit [5:0] wa, input bit [15:0] d,
                         input bit r, input bit [5:0] ra);
        wr = w; waddr = wa; d_in = d; rd = r; raddr = ra;
        @(posedge clk);
        if (rst) begin
            if (r) model_q = model_mem[ra];
            if (w) model_mem[wa] = d;
        end
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{1, 6'h01, 16'hADCA, 0, 6'h00, 16'h0000},
            '{1, 6'h06, 16'h5767, 0, 6'h00, 16'h0000},
            '{1, 6'h33, 16'hA7CD, 0, 6'h00, 16'h0000},
            '{1, 6'h1F, 16'hA23D, 0, 6'h00, 16'h0000},
            '{1, 6'h3F, 16'h1234, 0, 6'h00, 16'h0000},
            '{0, 6'h00, 16'h0000, 1, 6'h01, 16'hADCA},
            '{0, 6'h00, 16'h0000, 1, 6'h06, 16'h5767},
            '{0, 6'h00, 16'h0000, 1, 6'h33, 16'hA7CD},
            '{0, 6'h00, 16'h0000, 1, 6'h1F, 16'hA23D},
            '{0, 6'h00, 16'h0000, 1, 6'h3F, 16'h1234},
            '{1, 6'h06, 16'hBEEF, 1, 6'h06, 16'h5767},
            '{0, 6'h00, 16'h0000, 1, 6'h06, 16'hBEEF},
            '{0, 6'h00, 16'h0000, 1, 6'h33, 16'hA7CD},
            '{1, 6'h33, 16'h0000, 0, 6'h00, 16'hA7CD},
            '{0, 6'h00, 16'h0000, 1, 6'h33, 16'h0000},
            '{1, 6'h3F, 16'h5555, 1, 6'h1F, 16'hA23D},
            '{0, 6'h00, 16'h0000, 1, 6'h3F, 16'h5555},
            '{0, 6'h00, 16'h0000, 1, 6'h01, 16'hADCA}
        };

        rst = 1'b0; wr = 1'b0; rd = 1'b0; waddr = '0; raddr = '0; d_in = '0;
        model_reset();
        #2;
        chk("reset_async_dout", d_out, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset_release_dout", d_out, 16'h0000);

        foreach (vecs[i]) begin
            cycle(vecs[i].wr, vecs[i].waddr, vecs[i].d, vecs[i].rd, vecs[i].raddr);
            chk($sformatf("vec%0d", i), d_out, vecs[i].exp);
        end

        // Reset with contents present: one cycle low, then every address reads zero.
        #2 rst = 1'b0;
        model_reset();
        #1 chk("rst1_async", d_out, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b1;
        foreach (vecs[i]) if (vecs[i].wr) begin
            cycle(0, 6'h00, 16'h0000, 1, vecs[i].waddr);
            chk($sformatf("rst1_clear_%02h", vecs[i].waddr), d_out, 16'h0000);
        end

        // Mid-burst reset: dropped between edges, accesses held active through a reset edge.
        cycle(1, 6'h01, 16'h9C3A, 0, 6'h00);
        cycle(1, 6'h22, 16'h4411, 1, 6'h01);
        chk("burst_rd_01", d_out, 16'h9C3A);
        wr = 1'b1; waddr = 6'h01; d_in = 16'h7777; rd = 1'b1; raddr = 6'h22;
        #2 rst = 1'b0;
        model_reset();
        #1 chk("rst2_async", d_out, 16'h0000);
        @(posedge clk);
        #1 chk("rst2_hold_edge", d_out, 16'h0000);
        rst = 1'b1;
        cycle(0, 6'h00, 16'h0000, 1, 6'h01);
        chk("rst2_read_01", d_out, 16'h0000);
        cycle(0, 6'h00, 16'h0000, 1, 6'h22);
        chk("rst2_read_22", d_out, 16'h0000);
        cycle(1, 6'h01, 16'h0F0F, 1, 6'h01);
        chk("rst2_first_access", d_out, 16'h0000);
        cycle(0, 6'h00, 16'h0000, 1, 6'h01);
        chk("rst2_first_write", d_out, 16'h0F0F);

        // Random traffic against the array model; frequent same-address and bank-edge hits.
        for (int n = 0; n < 400; n++) begin
            bit [5:0] wa, ra;
            wa = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0:       ra = wa;
                1:       ra = wa ^ 6'h20;
                default: ra = 6'($urandom_range(0, 63));
            endcase
            cycle(1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 1)), ra);
            chk($sformatf("rand%0d", n), d_out, model_q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
